// File: rtl/frac_lut6_ccff_loader_if.sv
// Configuration word handshake between the bus front-end (master) and the
// frac_lut6 chain loader (slave).
interface frac_lut6_ccff_loader_if #(
    parameter int CHAIN_LEN = 66
);
    logic                 load_valid;
    logic                 load_ready;
    logic [CHAIN_LEN-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/frac_lut6_ccff_loader.sv
// Loads one frac_lut6 DFFR configuration chain serially (MSB first) and
// captures the previous chain contents from the tail for readback.
module frac_lut6_ccff_loader #(
    parameter int CHAIN_LEN = 66,
    parameter int CNT_W     = 7
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    frac_lut6_ccff_loader_if.slave load,
    output logic                   ccff_head_out,
    input  logic                   ccff_tail_in,
    output logic                   chain_en,
    output logic                   busy,
    output logic                   done,
    output logic [CHAIN_LEN-1:0]   rdback_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [CHAIN_LEN-1:0] shreg_q,      shreg_d;
    logic [CHAIN_LEN-1:0] rdback_q,     rdback_d;
    logic                 load_ready_q, load_ready_d;
    logic                 chain_en_q,   chain_en_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;

    logic [CNT_W-1:0]     bit_idx;
    logic                 last_bit;
    logic                 accept;

    // Bit k of the shift leaves from position CHAIN_LEN-1-k, and the tail bit
    // seen on that edge belongs to the same chain position of the old word.
    assign bit_idx  = CNT_W'(CHAIN_LEN - 1) - cnt_q;
    assign last_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign accept   = load.load_valid && load_ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        rdback_d     = rdback_q;
        load_ready_d = 1'b0;
        chain_en_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready_d = 1'b1;
                if (accept) begin
                    shreg_d      = load.load_data;
                    cnt_d        = '0;
                    state_d      = ST_SHIFT;
                    load_ready_d = 1'b0;
                    chain_en_d   = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_SHIFT: begin
                rdback_d[bit_idx] = ccff_tail_in;
                if (last_bit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    chain_en_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                load_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            rdback_q     <= '0;
            load_ready_q <= 1'b0;
            chain_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            rdback_q     <= rdback_d;
            load_ready_q <= load_ready_d;
            chain_en_q   <= chain_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ccff_head_out   = (state_q == ST_SHIFT) ? shreg_q[bit_idx] : 1'b0;
    assign load.load_ready = load_ready_q;
    assign chain_en        = chain_en_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign rdback_data     = rdback_q;

endmodule

// File: tb/tb_frac_lut6_ccff_loader.sv
// Self-checking bench for frac_lut6_ccff_loader with a behavioural 66-flop chain.
module tb_frac_lut6_ccff_loader;

    localparam int N = 66;

    typedef struct {
        logic [N-1:0] word;
        logic [N-1:0] exp_rd;
    } vec_t;

    logic         prog_clk;
    logic         pReset;
    logic         ccff_head_out;
    logic         ccff_tail_in;
    logic         chain_en;
    logic         busy;
    logic         done;
    logic [N-1:0] rdback_data;

    logic [N-1:0] chain_m = '0;
    logic [N-1:0] last_word = '0;
    int           checks = 0;
    int           errors = 0;

    frac_lut6_ccff_loader_if #(.CHAIN_LEN(N)) load_if ();

    frac_lut6_ccff_loader #(.CHAIN_LEN(N), .CNT_W(7)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .load          (load_if.slave),
        .ccff_head_out (ccff_head_out),
        .ccff_tail_in  (ccff_tail_in),
        .chain_en      (chain_en),
        .busy          (busy),
        .done          (done),
        .rdback_data   (rdback_data)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Target chain: new bit enters position 0, tail is position N-1.
    always @(posedge prog_clk) begin
        if (chain_en) chain_m <= {chain_m[N-2:0], ccff_head_out};
    end
    assign ccff_tail_in = chain_m[N-1];

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[N-1:0];
    endfunction

    // Called on a negedge; returns on the negedge of the first IDLE cycle after DONE.
    task automatic do_load(input logic [N-1:0] w, input logic [N-1:0] exp_rd, input string tag);
        int n;
        int en_cnt, busy_cnt, done_cnt, rdy_cnt;
        logic [N-1:0] head_cap;
        n = 0;
        while (!load_if.load_ready && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        chk({tag, "_ready_wait"}, N'(n < 100), N'(1));
        load_if.load_valid = 1'b1;
        load_if.load_data  = w;
        @(negedge prog_clk);
        load_if.load_valid = 1'b0;
        load_if.load_data  = ~w;
        head_cap = '0;
        en_cnt = 0; busy_cnt = 0; done_cnt = 0; rdy_cnt = 0;
        for (int k = 0; k < N; k++) begin
            head_cap[N-1-k] = ccff_head_out;
            en_cnt   += int'(chain_en);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            rdy_cnt  += int'(load_if.load_ready);
            @(negedge prog_clk);
        end
        chk({tag, "_head_seq"}, head_cap, w);
        chk({tag, "_en_cycles"}, N'(en_cnt), N'(N));
        chk({tag, "_busy_cycles"}, N'(busy_cnt), N'(N));
        chk({tag, "_done_early"}, N'(done_cnt), N'(0));
        chk({tag, "_ready_shift"}, N'(rdy_cnt), N'(0));
        chk({tag, "_done_pulse"}, N'(done), N'(1));
        chk({tag, "_en_done"}, N'(chain_en), N'(0));
        chk({tag, "_busy_done"}, N'(busy), N'(0));
        chk({tag, "_ready_done"}, N'(load_if.load_ready), N'(0));
        chk({tag, "_head_done"}, N'(ccff_head_out), N'(0));
        chk({tag, "_rdback"}, rdback_data, exp_rd);
        chk({tag, "_chain"}, chain_m, w);
        @(negedge prog_clk);
        chk({tag, "_done_clear"}, N'(done), N'(0));
        chk({tag, "_ready_idle"}, N'(load_if.load_ready), N'(1));
        last_word = w;
    endtask

    initial begin
        vec_t         vecs[3];
        logic [N-1:0] w;
        logic [N-1:0] pre;
        int           acc_cyc[$];
        logic [N-1:0] acc_w[$];
        int           cyc, n;

        vecs[0] = '{word: 66'h2_AAAA_AAAA_AAAA_AAAA, exp_rd: '0};
        vecs[1] = '{word: 66'h1_0123_4567_89AB_CDEF, exp_rd: 66'h2_AAAA_AAAA_AAAA_AAAA};
        vecs[2] = '{word: 66'h2_FEDC_BA98_7654_3210, exp_rd: 66'h1_0123_4567_89AB_CDEF};

        pReset = 1'b0;
        load_if.load_valid = 1'b0;
        load_if.load_data  = '0;
        repeat (3) @(negedge prog_clk);
        chk("rst_ready", N'(load_if.load_ready), N'(0));
        chk("rst_en", N'(chain_en), N'(0));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_head", N'(ccff_head_out), N'(0));
        chk("rst_rdback", rdback_data, '0);
        pReset = 1'b1;
        chk("ready_at_release", N'(load_if.load_ready), N'(0));
        @(negedge prog_clk);
        chk("ready_after_rst", N'(load_if.load_ready), N'(1));

        for (int i = 0; i < 3; i++) do_load(vecs[i].word, vecs[i].exp_rd, "vec");

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge prog_clk);
            w = rand_word();
            do_load(w, last_word, "rand");
        end

        // load_valid held high with data changing every cycle
        cyc = 0;
        load_if.load_valid = 1'b1;
        while (acc_cyc.size() < 3 && cyc < 400) begin
            load_if.load_data = rand_word();
            if (load_if.load_ready) begin
                acc_cyc.push_back(cyc);
                acc_w.push_back(load_if.load_data);
            end
            @(negedge prog_clk);
            cyc++;
        end
        load_if.load_valid = 1'b0;
        chk("hold_accepts", N'(acc_cyc.size()), N'(3));
        if (acc_cyc.size() == 3) begin
            chk("hold_space01", N'(acc_cyc[1] - acc_cyc[0]), N'(N + 2));
            chk("hold_space12", N'(acc_cyc[2] - acc_cyc[1]), N'(N + 2));
            n = 0;
            while (!done && n < 100) begin
                @(negedge prog_clk);
                n++;
            end
            chk("hold_done_seen", N'(done), N'(1));
            chk("hold_chain", chain_m, acc_w[2]);
            chk("hold_rdback", rdback_data, acc_w[1]);
            last_word = acc_w[2];
            @(negedge prog_clk);
        end

        // asynchronous reset in the middle of a shift
        load_if.load_valid = 1'b1;
        load_if.load_data  = rand_word();
        @(negedge prog_clk);
        load_if.load_valid = 1'b0;
        repeat (30) @(negedge prog_clk);
        chk("mid_en_before", N'(chain_en), N'(1));
        #2 pReset = 1'b0;
        #1;
        chk("mid_rst_en", N'(chain_en), N'(0));
        chk("mid_rst_busy", N'(busy), N'(0));
        chk("mid_rst_done", N'(done), N'(0));
        chk("mid_rst_ready", N'(load_if.load_ready), N'(0));
        chk("mid_rst_head", N'(ccff_head_out), N'(0));
        chk("mid_rst_rdback", rdback_data, '0);
        @(negedge prog_clk);
        pReset = 1'b1;
        @(negedge prog_clk);
        chk("mid_ready_after", N'(load_if.load_ready), N'(1));
        pre = chain_m;
        do_load('1, pre, "ones");
        do_load('0, '1, "zeros");

        // final shift carries bit 0; rdback[0] holds old position 0
        do_load(66'h1, '0, "bnd_pre");
        do_load(66'h1, 66'h1, "bnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
